bg_theme_controller: RTL and testbench

BG_THEME_CONTROLLER -- requirements
Module: bg_theme_controller

---
 rtl/bg_theme_controller_if.sv | 22 ++
 rtl/bg_theme_controller.sv | 182 ++++++++++++++++++
 tb/tb_bg_theme_controller.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/bg_theme_controller_if.sv
// Frame-timing, level-select and flash-handshake bundle between the frame
// sequencer (master) and bg_theme_controller (slave).
interface bg_theme_controller_if;
    logic       startOfFrame;
    logic [2:0] levelNum;
    logic       levelLoad;
    logic       flashReq;
    logic       flashAck;
    logic       busy;
    logic [7:0] borderRGB;
    logic [7:0] fillRGB;

    modport master (
        output startOfFrame, levelNum, levelLoad, flashReq,
        input  flashAck, busy, borderRGB, fillRGB
    );

    modport slave (
        input  startOfFrame, levelNum, levelLoad, flashReq,
        output flashAck, busy, borderRGB, fillRGB
    );
endinterface

// File: rtl/bg_theme_controller.sv
// Background theme controller: frame-aligned level palette plus an optional
// white flash sequencer, compiled in only when BG_FLASH_EN is defined.
//
// state     | meaning
// IDLE      | no flash pending; a flashReq is acknowledged and arms a flash
// ARMED     | flash accepted, waiting for the next frame start
// FLASH_ON  | border and fill forced white for FLASH_FRAMES frames
// FLASH_OFF | level palette shown for FLASH_FRAMES frames, then next toggle
module bg_theme_controller #(
    parameter int FLASH_FRAMES  = 8,
    parameter int FLASH_TOGGLES = 3
) (
    input  logic                   clk,
    input  logic                   resetN,
    bg_theme_controller_if.slave   bus
);

    localparam logic [7:0] BORDER_NORMAL = 8'hFC;
    localparam logic [7:0] FLASH_WHITE   = 8'hFF;
    localparam logic [7:0] FILL_RESET    = 8'h03;

    function automatic logic [7:0] palette(input logic [2:0] lvl);
        logic [7:0] rgb;
        case (lvl)
            3'd0:    rgb = 8'h03;
            3'd1:    rgb = 8'h58;
            3'd2:    rgb = 8'hE0;
            3'd3:    rgb = 8'h1C;
            3'd4:    rgb = 8'hA2;
            3'd5:    rgb = 8'h4B;
            3'd6:    rgb = 8'h90;
            default: rgb = 8'h6D;
        endcase
        return rgb;
    endfunction

    logic [2:0] pend_level_q, pend_level_d;
    logic       pend_valid_q, pend_valid_d;
    logic [2:0] act_level_q,  act_level_d;
    logic [7:0] border_q,     border_d;
    logic [7:0] fill_q,       fill_d;
    logic       flash_white_d;

    // A coincident load is captured after the old pending value is applied.
    always_comb begin
        pend_level_d = pend_level_q;
        pend_valid_d = pend_valid_q;
        act_level_d  = act_level_q;
        if (bus.startOfFrame && pend_valid_q) begin
            act_level_d  = pend_level_q;
            pend_valid_d = 1'b0;
        end
        if (bus.levelLoad) begin
            pend_level_d = bus.levelNum;
            pend_valid_d = 1'b1;
        end
    end

    always_comb begin
        border_d = border_q;
        fill_d   = fill_q;
        if (bus.startOfFrame) begin
            if (flash_white_d) begin
                border_d = FLASH_WHITE;
                fill_d   = FLASH_WHITE;
            end else begin
                border_d = BORDER_NORMAL;
                fill_d   = palette(act_level_d);
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            pend_level_q <= 3'd0;
            pend_valid_q <= 1'b0;
            act_level_q  <= 3'd0;
            border_q     <= BORDER_NORMAL;
            fill_q       <= FILL_RESET;
        end else begin
            pend_level_q <= pend_level_d;
            pend_valid_q <= pend_valid_d;
            act_level_q  <= act_level_d;
            border_q     <= border_d;
            fill_q       <= fill_d;
        end
    end

    assign bus.borderRGB = border_q;
    assign bus.fillRGB   = fill_q;

`ifdef BG_FLASH_EN
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ARMED     = 2'd1,
        FLASH_ON  = 2'd2,
        FLASH_OFF = 2'd3
    } state_t;

    localparam logic [7:0] FRAME_LIM  = 8'(FLASH_FRAMES);
    localparam logic [3:0] TOGGLE_LIM = 4'(FLASH_TOGGLES);

    state_t     state_q,  state_d;
    logic [7:0] frame_q,  frame_d;
    logic [3:0] toggle_q, toggle_d;
    logic       ack_q,    ack_d;

    always_comb begin
        state_d  = state_q;
        frame_d  = frame_q;
        toggle_d = toggle_q;
        ack_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.flashReq) begin
                    ack_d   = 1'b1;
                    state_d = ARMED;
                end
            end
            ARMED: begin
                if (bus.startOfFrame) begin
                    state_d = FLASH_ON;
                    frame_d = 8'd0;
                end
            end
            FLASH_ON: begin
                if (bus.startOfFrame) begin
                    if (frame_q + 8'd1 == FRAME_LIM) begin
                        state_d = FLASH_OFF;
                        frame_d = 8'd0;
                    end else begin
                        frame_d = frame_q + 8'd1;
                    end
                end
            end
            FLASH_OFF: begin
                if (bus.startOfFrame) begin
                    if (frame_q + 8'd1 == FRAME_LIM) begin
                        frame_d = 8'd0;
                        if (toggle_q + 4'd1 == TOGGLE_LIM) begin
                            toggle_d = 4'd0;
                            state_d  = IDLE;
                        end else begin
                            toggle_d = toggle_q + 4'd1;
                            state_d  = FLASH_ON;
                        end
                    end else begin
                        frame_d = frame_q + 8'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign flash_white_d = (state_d == FLASH_ON);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q  <= IDLE;
            frame_q  <= 8'd0;
            toggle_q <= 4'd0;
            ack_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            frame_q  <= frame_d;
            toggle_q <= toggle_d;
            ack_q    <= ack_d;
        end
    end

    assign bus.flashAck = ack_q;
    assign bus.busy     = (state_q != IDLE);
`else
    logic unused_flash_req;
    assign unused_flash_req = bus.flashReq;
    assign flash_white_d    = 1'b0;
    assign bus.flashAck     = 1'b0;
    assign bus.busy         = 1'b0;
`endif

endmodule

// File: tb/tb_bg_theme_controller.sv
// Directed bench for bg_theme_controller: level staging, frame alignment,
// reset behaviour and, when BG_FLASH_EN is defined, the flash sequence.
module tb_bg_theme_controller;

    logic clk;
    logic resetN;
    int   vectors;
    int   miscompares;

    bg_theme_controller_if bus();

    bg_theme_controller #(
        .FLASH_FRAMES  (2),
        .FLASH_TOGGLES (2)
    ) dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        vectors++;
        assert (obs === exp_v)
        else begin
            miscompares++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One frame: start pulse, then three mid-frame cycles that must hold the outputs.
    task automatic frame(input string tag, input logic [7:0] eb, input logic [7:0] ef,
                         input logic ebusy);
        bus.startOfFrame = 1'b1;
        step();
        bus.startOfFrame = 1'b0;
        chk({tag, " border"}, bus.borderRGB, eb);
        chk({tag, " fill"},   bus.fillRGB,   ef);
        chk({tag, " busy"},   {7'd0, bus.busy},     {7'd0, ebusy});
        chk({tag, " ack"},    {7'd0, bus.flashAck}, 8'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk({tag, " hold fill"}, bus.fillRGB, ef);
            chk({tag, " hold ack"},  {7'd0, bus.flashAck}, 8'd0);
        end
    endtask

    initial begin
        vectors            = 0;
        miscompares        = 0;
        bus.startOfFrame   = 1'b0;
        bus.levelNum       = 3'd0;
        bus.levelLoad      = 1'b0;
        bus.flashReq       = 1'b1;
        resetN             = 1'b1;
        #3;
        resetN = 1'b0;
        #1;
        chk("reset border", bus.borderRGB, 8'hFC);
        chk("reset fill",   bus.fillRGB,   8'h03);
        chk("reset busy",   {7'd0, bus.busy},     8'd0);
        chk("reset ack",    {7'd0, bus.flashAck}, 8'd0);
        step();
        step();
        bus.flashReq = 1'b0;
        resetN = 1'b1;
        step();

        for (int f = 0; f < 3; f++) frame("idle", 8'hFC, 8'h03, 1'b0);

        // Level 2 loaded mid-frame appears only after the next frame start.
        step();
        bus.levelNum  = 3'd2;
        bus.levelLoad = 1'b1;
        step();
        bus.levelLoad = 1'b0;
        chk("lvl2 pending fill", bus.fillRGB, 8'h03);
        step();
        chk("lvl2 pending fill2", bus.fillRGB, 8'h03);
        frame("lvl2", 8'hFC, 8'hE0, 1'b0);

        // Later load in the same frame overwrites the earlier one.
        bus.levelNum  = 3'd4;
        bus.levelLoad = 1'b1;
        step();
        bus.levelNum  = 3'd5;
        step();
        bus.levelLoad = 1'b0;
        chk("lvl4/5 pending fill", bus.fillRGB, 8'hE0);
        frame("lvl5", 8'hFC, 8'h4B, 1'b0);

        // Load coincident with frame start: old pending applied, new one held.
        bus.levelNum  = 3'd6;
        bus.levelLoad = 1'b1;
        step();
        bus.levelLoad = 1'b0;
        step();
        bus.levelNum     = 3'd7;
        bus.levelLoad    = 1'b1;
        bus.startOfFrame = 1'b1;
        step();
        bus.levelLoad    = 1'b0;
        bus.startOfFrame = 1'b0;
        chk("coincident old applied", bus.fillRGB, 8'h90);
        step();
        frame("coincident new applied", 8'hFC, 8'h6D, 1'b0);
        frame("no pending no change",   8'hFC, 8'h6D, 1'b0);

        bus.levelNum  = 3'd2;
        bus.levelLoad = 1'b1;
        step();
        bus.levelLoad = 1'b0;
        frame("lvl2 again", 8'hFC, 8'hE0, 1'b0);

`ifdef BG_FLASH_EN
        bus.flashReq = 1'b1;
        step();
        chk("flash ack",       {7'd0, bus.flashAck}, 8'd1);
        chk("flash armed busy", {7'd0, bus.busy},    8'd1);
        chk("armed fill",      bus.fillRGB, 8'hE0);
        step();
        chk("flash ack single", {7'd0, bus.flashAck}, 8'd0);
        chk("armed busy",       {7'd0, bus.busy},     8'd1);
        frame("on1",  8'hFF, 8'hFF, 1'b1);
        frame("on2",  8'hFF, 8'hFF, 1'b1);
        frame("off1", 8'hFC, 8'hE0, 1'b1);
        frame("off2", 8'hFC, 8'hE0, 1'b1);
        frame("on3",  8'hFF, 8'hFF, 1'b1);
        frame("on4",  8'hFF, 8'hFF, 1'b1);
        frame("off3", 8'hFC, 8'hE0, 1'b1);
        frame("off4", 8'hFC, 8'hE0, 1'b1);
        bus.startOfFrame = 1'b1;
        step();
        bus.startOfFrame = 1'b0;
        chk("done fill",   bus.fillRGB, 8'hE0);
        chk("done border", bus.borderRGB, 8'hFC);
        chk("done busy",   {7'd0, bus.busy},     8'd0);
        chk("done ack",    {7'd0, bus.flashAck}, 8'd0);
        step();
        chk("second ack",  {7'd0, bus.flashAck}, 8'd1);
        chk("second busy", {7'd0, bus.busy},     8'd1);
        bus.flashReq = 1'b0;
        step();
        chk("second ack single", {7'd0, bus.flashAck}, 8'd0);
        frame("second on", 8'hFF, 8'hFF, 1'b1);
`else
        bus.flashReq = 1'b1;
        for (int f = 0; f < 10; f++) frame("noflash", 8'hFC, 8'hE0, 1'b0);
        bus.flashReq = 1'b0;
`endif

        // Reset with a pending level (and mid-flash when enabled) discards everything.
        bus.levelNum  = 3'd5;
        bus.levelLoad = 1'b1;
        step();
        bus.levelLoad = 1'b0;
        #2;
        resetN = 1'b0;
        #1;
        chk("midreset border", bus.borderRGB, 8'hFC);
        chk("midreset fill",   bus.fillRGB,   8'h03);
        chk("midreset busy",   {7'd0, bus.busy},     8'd0);
        chk("midreset ack",    {7'd0, bus.flashAck}, 8'd0);
        step();
        resetN = 1'b1;
        step();
        frame("post reset 1", 8'hFC, 8'h03, 1'b0);
        frame("post reset 2", 8'hFC, 8'h03, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "bench time limit exceeded");
    end

endmodule
